// File: rtl/tmds_ser2par_align_pkg.sv
// Shared TMDS receive definitions: symbol geometry, control tokens and
// the alignment state encoding. Also used by the par2ser transmit side.
package tmds_rx_pkg;

  localparam int SYM_W         = 10;
  localparam int PAIRS_PER_SYM = 5;

  // Control tokens in LSB-first (first bit on the wire = bit 0) view.
  localparam logic [SYM_W-1:0] TOK_CTL0 = 10'h354;
  localparam logic [SYM_W-1:0] TOK_CTL1 = 10'h0AB;
  localparam logic [SYM_W-1:0] TOK_CTL2 = 10'h154;
  localparam logic [SYM_W-1:0] TOK_CTL3 = 10'h2AB;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  function automatic logic is_ctrl_token(input logic [SYM_W-1:0] sym);
    return (sym == TOK_CTL0) || (sym == TOK_CTL1) ||
           (sym == TOK_CTL2) || (sym == TOK_CTL3);
  endfunction

endpackage

// File: rtl/tmds_ser2par_align_if.sv
// Bit-pair input and aligned-symbol output bundle of the TMDS aligner.
// master = capture/consumer side, slave = aligner.
interface tmds_ser2par_align_if;
  import tmds_rx_pkg::*;

  logic             clk_en;
  logic             datain_h;
  logic             datain_l;
  logic [SYM_W-1:0] dataout;
  logic             valid;
  logic             locked;
  logic [3:0]       offset;
  logic             token_det;

  modport master (
    output clk_en, datain_h, datain_l,
    input  dataout, valid, locked, offset, token_det
  );

  modport slave (
    input  clk_en, datain_h, datain_l,
    output dataout, valid, locked, offset, token_det
  );

endinterface

// File: rtl/tmds_ser2par_align_token_det.sv
// Registered control-token comparator; hit lines up with the registered
// symbol it was computed from and is low whenever en was low.
module tmds_token_det
  import tmds_rx_pkg::*;
(
  input  logic             clk,
  input  logic             sclr,
  input  logic             en,
  input  logic [SYM_W-1:0] sym,
  output logic             hit
);

  logic hit_d, hit_q;

  // match the candidate symbol against the token set
  always_comb begin
    hit_d = en && is_ctrl_token(sym);
  end

  // register the match alongside the symbol
  always_ff @(posedge clk) begin
    if (sclr) hit_q <= 1'b0;
    else      hit_q <= hit_d;
  end

  assign hit = hit_q;

endmodule

// File: rtl/tmds_ser2par_align.sv
// Rebuilds 10-bit TMDS symbols from DDR bit pairs and slides the symbol
// window one bit at a time until control tokens line up.
//
//  state  | meaning
//  SEARCH | hunting for a token at the current offset
//  VERIFY | token seen, counting consecutive tokens at this offset
//  LOCKED | aligned; watching for a prolonged absence of tokens
module tmds_ser2par_align
  import tmds_rx_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int SEARCH_WIN = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                 clk,
  input  logic                 sclr,
  tmds_ser2par_align_if.slave  bus
);

  localparam int TOK_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W = $clog2(SEARCH_WIN + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_SEARCH = 2'(SEARCH);
  localparam logic [1:0] ST_VERIFY = 2'(VERIFY);
  localparam logic [1:0] ST_LOCKED = 2'(LOCKED);
  localparam logic [2:0] PH_LAST   = 3'(PAIRS_PER_SYM - 1);

  function automatic logic [3:0] next_offset(input logic [3:0] o);
    return (o == 4'd9) ? 4'd0 : o + 4'd1;
  endfunction

  logic [19:0]      sr_d, sr_q, sr_next;
  logic [29:0]      sr_ext;
  logic [2:0]       ph_d, ph_q;
  logic [1:0]       state_d, state_q;
  logic [3:0]       offset_d, offset_q;
  logic [TOK_W-1:0] tok_cnt_d, tok_cnt_q;
  logic [WIN_W-1:0] win_cnt_d, win_cnt_q;
  logic [TO_W-1:0]  to_cnt_d, to_cnt_q;
  logic             flush_d, flush_q;
  logic [SYM_W-1:0] dataout_d, dataout_q;
  logic             valid_d, valid_q;
  logic             locked_d, locked_q;
  logic [SYM_W-1:0] sym_win;
  logic             sym_tick;
  logic             is_tok;
  logic             token_det_w;

  // next shift-register value, symbol window and alignment state machine
  always_comb begin
    sr_next   = {bus.datain_l, bus.datain_h, sr_q[19:2]};
    // zero padding keeps the variable select in range for every 4-bit offset
    sr_ext    = {10'd0, sr_next};
    sym_win   = sr_ext[offset_q +: SYM_W];
    sym_tick  = bus.clk_en && (ph_q == PH_LAST);
    is_tok    = is_ctrl_token(sym_win);

    sr_d      = sr_q;
    ph_d      = ph_q;
    state_d   = state_q;
    offset_d  = offset_q;
    tok_cnt_d = tok_cnt_q;
    win_cnt_d = win_cnt_q;
    to_cnt_d  = to_cnt_q;
    flush_d   = flush_q;
    locked_d  = locked_q;
    valid_d   = sym_tick;
    dataout_d = sym_tick ? sym_win : dataout_q;

    if (bus.clk_en) begin
      sr_d = sr_next;
      ph_d = (ph_q == PH_LAST) ? 3'd0 : ph_q + 3'd1;
    end

    if (sym_tick) begin
      if (flush_q) begin
        // first symbol after an offset move straddles both alignments
        flush_d = 1'b0;
      end else begin
        case (state_q)
          ST_SEARCH: begin
            if (is_tok) begin
              state_d   = ST_VERIFY;
              tok_cnt_d = TOK_W'(1);
              win_cnt_d = '0;
            end else if (win_cnt_q == WIN_W'(SEARCH_WIN - 1)) begin
              offset_d  = next_offset(offset_q);
              win_cnt_d = '0;
              flush_d   = 1'b1;
            end else begin
              win_cnt_d = win_cnt_q + WIN_W'(1);
            end
          end
          ST_VERIFY: begin
            if (is_tok) begin
              if (tok_cnt_q == TOK_W'(LOCK_CNT - 1)) begin
                state_d   = ST_LOCKED;
                locked_d  = 1'b1;
                tok_cnt_d = '0;
                to_cnt_d  = '0;
              end else begin
                tok_cnt_d = tok_cnt_q + TOK_W'(1);
              end
            end else begin
              state_d   = ST_SEARCH;
              offset_d  = next_offset(offset_q);
              flush_d   = 1'b1;
              tok_cnt_d = '0;
              win_cnt_d = '0;
            end
          end
          ST_LOCKED: begin
            if (is_tok) begin
              to_cnt_d = '0;
            end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
              // offset is kept: the link most likely comes back where it was
              state_d   = ST_SEARCH;
              locked_d  = 1'b0;
              to_cnt_d  = '0;
              win_cnt_d = '0;
            end else begin
              to_cnt_d = to_cnt_q + TO_W'(1);
            end
          end
          default: begin
            state_d   = ST_SEARCH;
            locked_d  = 1'b0;
            tok_cnt_d = '0;
            win_cnt_d = '0;
            to_cnt_d  = '0;
          end
        endcase
      end
    end
  end

  // state registers with synchronous clear
  always_ff @(posedge clk) begin
    if (sclr) begin
      sr_q      <= '0;
      ph_q      <= '0;
      state_q   <= ST_SEARCH;
      offset_q  <= '0;
      tok_cnt_q <= '0;
      win_cnt_q <= '0;
      to_cnt_q  <= '0;
      flush_q   <= 1'b0;
      dataout_q <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      ph_q      <= ph_d;
      state_q   <= state_d;
      offset_q  <= offset_d;
      tok_cnt_q <= tok_cnt_d;
      win_cnt_q <= win_cnt_d;
      to_cnt_q  <= to_cnt_d;
      flush_q   <= flush_d;
      dataout_q <= dataout_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
    end
  end

  tmds_token_det u_token_det (
    .clk  (clk),
    .sclr (sclr),
    .en   (sym_tick),
    .sym  (sym_win),
    .hit  (token_det_w)
  );

  assign bus.dataout   = dataout_q;
  assign bus.valid     = valid_q;
  assign bus.locked    = locked_q;
  assign bus.offset    = offset_q;
  assign bus.token_det = token_det_w;

endmodule

// File: tb/tb_tmds_ser2par_align.sv
// Directed bench for the TMDS symbol aligner. With offset 0 the window
// emitted after sending symbol k holds symbol k-1 (the one before it).
module tb_tmds_ser2par_align;

  logic clk;
  logic sclr;
  int   n_pass;
  int   n_chk;

  tmds_ser2par_align_if bus ();

  tmds_ser2par_align #(
    .LOCK_CNT   (4),
    .SEARCH_WIN (16),
    .TIMEOUT    (4096)
  ) dut (
    .clk  (clk),
    .sclr (sclr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pair(input logic h, input logic l);
    bus.clk_en   = 1'b1;
    bus.datain_h = h;
    bus.datain_l = l;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clk_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [9:0] s);
    for (int i = 0; i < 5; i++) pair(s[2*i], s[2*i+1]);
  endtask

  task automatic do_reset();
    sclr       = 1'b1;
    bus.clk_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    sclr = 1'b0;
  endtask

  initial begin
    int prev_off, last_v, nsteps, lock_v, early_drop;
    logic lock_seen;
    logic [9:0] sym;

    clk          = 1'b0;
    sclr         = 1'b1;
    n_pass       = 0;
    n_chk        = 0;
    bus.clk_en   = 1'b0;
    bus.datain_h = 1'b0;
    bus.datain_l = 1'b0;

    // ---- reset values, aligned 10'h354 stream, lock on 4th token ----
    do_reset();
    chk("rst_dataout", bus.dataout, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_offset", bus.offset, 0);
    chk("rst_token_det", bus.token_det, 0);
    for (int k = 0; k < 5; k++) begin
      send_sym(10'h354);
      chk("al_valid", bus.valid, 1);
      chk("al_dataout", bus.dataout, (k == 0) ? 32'h0 : 32'h354);
      chk("al_locked", bus.locked, (k == 4) ? 1 : 0);
    end
    chk("al_offset", bus.offset, 0);

    // ---- timeout: 4096 non-token symbols after lock ----
    send_sym(10'h000);
    chk("to_tok_last", bus.token_det, 1);
    early_drop = 0;
    for (int j = 6; j <= 4100; j++) begin
      send_sym(10'h000);
      if (!bus.locked) early_drop++;
    end
    chk("to_no_early_drop", early_drop, 0);
    chk("to_locked_4095", bus.locked, 1);
    send_sym(10'h000);
    chk("to_locked_4096", bus.locked, 0);
    chk("to_offset_kept", bus.offset, 0);
    chk("to_token_det", bus.token_det, 0);

    // ---- broken verify: two tokens then data ----
    do_reset();
    send_sym(10'h354);
    send_sym(10'h354);
    chk("bv_tok1", bus.token_det, 1);
    send_sym(10'h1F0);
    chk("bv_tok2", bus.token_det, 1);
    chk("bv_off_before", bus.offset, 0);
    send_sym(10'h1F0);
    chk("bv_dataout", bus.dataout, 10'h1F0);
    chk("bv_token_det", bus.token_det, 0);
    chk("bv_offset", bus.offset, 1);
    chk("bv_locked", bus.locked, 0);
    // flush + 16 fresh search symbols: next step comes exactly 17 valids later
    for (int j = 4; j <= 19; j++) send_sym(10'h1F0);
    chk("bv_search_hold", bus.offset, 1);
    send_sym(10'h1F0);
    chk("bv_search_step", bus.offset, 2);

    // ---- misaligned: 10'h0AB rotated so boundary sits at bit 7 ----
    // symbol sent each time is 0AB rotated right by 3 = 10'h195
    do_reset();
    sym       = 10'h195;
    prev_off  = 0;
    last_v    = 0;
    nsteps    = 0;
    lock_v    = 0;
    lock_seen = 1'b0;
    for (int v = 1; v <= 140; v++) begin
      send_sym(sym);
      if (int'(bus.offset) != prev_off) begin
        chk("ma_off_step", bus.offset, prev_off + 1);
        chk("ma_off_gap", v - last_v, (nsteps == 0) ? 16 : 17);
        last_v   = v;
        prev_off = int'(bus.offset);
        nsteps++;
      end
      if (bus.locked) begin
        lock_v    = v;
        lock_seen = 1'b1;
        break;
      end
    end
    chk("ma_lock_seen", lock_seen, 1);
    chk("ma_lock_valid_idx", lock_v, 123);
    chk("ma_steps", nsteps, 7);
    chk("ma_offset", bus.offset, 7);
    chk("ma_dataout", bus.dataout, 10'h0AB);
    chk("ma_token_det", bus.token_det, 1);

    // ---- sclr mid-symbol while locked at offset 7 ----
    pair(1'b0, 1'b1);
    pair(1'b1, 1'b0);
    sclr = 1'b1;
    pair(1'b1, 1'b1);
    sclr = 1'b0;
    chk("sc_dataout", bus.dataout, 0);
    chk("sc_valid", bus.valid, 0);
    chk("sc_locked", bus.locked, 0);
    chk("sc_offset", bus.offset, 0);
    chk("sc_token_det", bus.token_det, 0);
    for (int i = 0; i < 4; i++) begin
      pair(1'b1, 1'b0);
      chk("sc_no_early_valid", bus.valid, 0);
    end
    pair(1'b1, 1'b0);
    chk("sc_valid_5th", bus.valid, 1);
    chk("sc_dataout_zero", bus.dataout, 0);
    pair(1'b1, 1'b0);
    chk("sc_valid_strobe", bus.valid, 0);

    // ---- stall mid-symbol: no valid, content intact ----
    do_reset();
    send_sym(10'h354);
    sym = 10'h0AB;
    pair(sym[0], sym[1]);
    pair(sym[2], sym[3]);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("st_no_valid", bus.valid, 0);
    end
    pair(sym[4], sym[5]);
    chk("st_resume_0", bus.valid, 0);
    pair(sym[6], sym[7]);
    chk("st_resume_1", bus.valid, 0);
    pair(sym[8], sym[9]);
    chk("st_valid", bus.valid, 1);
    chk("st_prev_sym", bus.dataout, 10'h354);
    send_sym(10'h354);
    chk("st_sym_intact", bus.dataout, 10'h0AB);
    chk("st_token_det", bus.token_det, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
